bitstream_word_packer: RTL and testbench

Downstream consumer of the `set_bit` byte output in the ProRes encoder top level. It accepts 0–8 bitstream bytes per cycle from `set_bit`, buffers them in a byte FIFO, and emits big-endian 32-bit words over a valid/ready handshake to the frame memory writer. On flush it drains the FIFO and marks the final, zero-padded word with `out_last`. It also keeps the running output byte total used for slice and frame size bookkeeping.

---
 rtl/bitstream_word_packer.sv | 171 +++++++++++++++++
 tb/tb_bitstream_word_packer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_word_packer.sv
// Byte-to-word packer behind set_bit: buffers 0..8 bytes per cycle in a byte FIFO
// and emits big-endian 32-bit words, with a flush that pads and marks the final word.
module bitstream_word_packer #(
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [3:0]               in_enable_byte,
   input  logic [63:0]              in_val,
   input  logic                     in_flush,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_data,
   output logic [2:0]               out_bytes,
   output logic                     out_last,
   output logic                     flush_done,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [31:0]              total_bytes
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned FW = AW + 1;

   typedef enum logic {
      RUN,
      DRAIN
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;

   logic [FW-1:0]   free_space;
   logic [FW-1:0]   avail;
   logic [7:0]      in_byte [8];
   logic [3:0]      push_n;
   logic            push_err;

   logic            accept;
   logic            load;
   logic            load_last;
   logic [2:0]      pop_n;
   logic [31:0]     load_data;
   logic [7:0]      sel_byte;
   logic [2:0]      in_idx;

   assign free_space = FW'(DEPTH) - fill_level;
   assign accept     = out_valid && out_ready;
   assign in_ready   = (state == RUN) && (free_space >= FW'(8));

   // Input bytes reordered so index 0 is first in stream order.
   always_comb begin
      for (int unsigned j = 0; j < 8; j++) begin
         in_byte[j] = 8'h00;
         if (j < 32'(in_enable_byte))
            in_byte[j] = 8'(in_val >> (8 * (32'(in_enable_byte) - 1 - j)));
      end
   end

   always_comb begin
      push_n   = '0;
      push_err = 1'b0;
      if (in_enable_byte != 4'd0) begin
         if (state == DRAIN || in_enable_byte > 4'd8 || free_space < FW'(in_enable_byte))
            push_err = 1'b1;
         else
            push_n = in_enable_byte;
      end
   end

   // Bytes arriving this cycle count toward the word so they can be output next cycle.
   assign avail = fill_level + FW'(push_n);

   always_comb begin
      load      = 1'b0;
      load_last = 1'b0;
      pop_n     = '0;
      if (!out_valid || accept) begin
         if (state == RUN) begin
            if (avail >= FW'(4)) begin
               load  = 1'b1;
               pop_n = 3'd4;
            end
         end else if (!(out_valid && out_last)) begin
            load = 1'b1;
            if (fill_level > FW'(4)) begin
               pop_n = 3'd4;
            end else begin
               pop_n     = 3'(fill_level);
               load_last = 1'b1;
            end
         end
      end
   end

   // Word bytes come from the FIFO first, then straight from the input bus.
   always_comb begin
      load_data = '0;
      sel_byte  = '0;
      in_idx    = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         sel_byte = 8'h00;
         in_idx   = 3'(k - 32'(fill_level));
         if (k < 32'(pop_n)) begin
            if (k < 32'(fill_level))
               sel_byte = mem[rd_ptr + AW'(k)];
            else
               sel_byte = in_byte[in_idx];
         end
         load_data = {load_data[23:0], sel_byte};
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (in_flush) state_next = DRAIN;
         DRAIN:   if (accept && out_last) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset_n) begin
         for (int unsigned j = 0; j < 8; j++) begin
            if (j < 32'(push_n))
               mem[wr_ptr + AW'(j)] <= in_byte[j];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= RUN;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fill_level  <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_bytes   <= '0;
         out_last    <= 1'b0;
         flush_done  <= 1'b0;
         overflow    <= 1'b0;
         total_bytes <= '0;
      end else begin
         state      <= state_next;
         wr_ptr     <= wr_ptr + AW'(push_n);
         rd_ptr     <= rd_ptr + AW'(pop_n);
         fill_level <= fill_level + FW'(push_n) - FW'(pop_n);
         flush_done <= accept && out_last;
         if (push_err)
            overflow <= 1'b1;
         if (accept)
            total_bytes <= total_bytes + 32'(out_bytes);
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_bytes <= pop_n;
            out_last  <= load_last;
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bitstream_word_packer.sv
// Scoreboard bench for bitstream_word_packer: a byte-stream model predicts each
// output word, and a negedge monitor compares accepted words against the queue.
module tb_bitstream_word_packer;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned FW    = $clog2(DEPTH) + 1;

   logic           clock = 1'b0;
   logic           reset_n;
   logic [3:0]     in_enable_byte;
   logic [63:0]    in_val;
   logic           in_flush;
   logic           in_ready;
   logic           out_valid;
   logic           out_ready;
   logic [31:0]    out_data;
   logic [2:0]     out_bytes;
   logic           out_last;
   logic           flush_done;
   logic           overflow;
   logic [FW-1:0]  fill_level;
   logic [31:0]    total_bytes;

   always #5 clock = ~clock;

   bitstream_word_packer #(.DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .in_enable_byte (in_enable_byte),
      .in_val         (in_val),
      .in_flush       (in_flush),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_bytes      (out_bytes),
      .out_last       (out_last),
      .flush_done     (flush_done),
      .overflow       (overflow),
      .fill_level     (fill_level),
      .total_bytes    (total_bytes)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [2:0]  b;
      logic        l;
   } word_t;

   word_t        exp_q[$];
   logic [7:0]   byte_q[$];
   word_t        mon_w;
   int unsigned  vectors     = 0;
   int unsigned  miscompares = 0;
   logic [31:0]  exp_total   = '0;
   logic         fd_pend     = 1'b0;
   logic         prev_stall  = 1'b0;
   logic [31:0]  prev_data   = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   always @(negedge clock) begin
      if (!reset_n) begin
         fd_pend    = 1'b0;
         prev_stall = 1'b0;
      end else begin
         check("flush_done", 32'(flush_done), 32'(fd_pend));
         fd_pend = 1'b0;
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_word", 32'(out_valid), 32'd0);
            end else begin
               mon_w = exp_q.pop_front();
               check("word_data", out_data, mon_w.d);
               check("word_bytes", 32'(out_bytes), 32'(mon_w.b));
               check("word_last", 32'(out_last), 32'(mon_w.l));
               exp_total = exp_total + 32'(mon_w.b);
               fd_pend   = mon_w.l;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int n, input logic [63:0] v, input bit acc);
      word_t w;
      in_enable_byte = 4'(n);
      in_val         = v;
      if (acc) begin
         for (int j = n - 1; j >= 0; j--)
            byte_q.push_back(8'(v >> (8 * j)));
         while (byte_q.size() >= 4) begin
            w.d = '0;
            for (int k = 0; k < 4; k++)
               w.d = {w.d[23:0], byte_q.pop_front()};
            w.b = 3'd4;
            w.l = 1'b0;
            exp_q.push_back(w);
         end
      end
      tick();
      in_enable_byte = '0;
      in_val         = '0;
   endtask

   task automatic flush(input bit marker);
      word_t w;
      int    r;
      in_flush = 1'b1;
      r = byte_q.size();
      if (r > 0) begin
         w.d = '0;
         for (int k = 0; k < 4; k++)
            w.d = {w.d[23:0], (k < r) ? byte_q.pop_front() : 8'h00};
         w.b = 3'(r);
         w.l = 1'b1;
         exp_q.push_back(w);
      end else if (marker) begin
         w.d = '0;
         w.b = '0;
         w.l = 1'b1;
         exp_q.push_back(w);
      end else begin
         w   = exp_q.pop_back();
         w.l = 1'b1;
         exp_q.push_back(w);
      end
      tick();
      in_flush = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid || fd_pend) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200)
         check("wait_timeout", 32'(n), 32'd0);
      tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_data"}, out_data, 32'd0);
      check({tag, "_bytes"}, 32'(out_bytes), 32'd0);
      check({tag, "_last"}, 32'(out_last), 32'd0);
      check({tag, "_fdone"}, 32'(flush_done), 32'd0);
      check({tag, "_ovf"}, 32'(overflow), 32'd0);
      check({tag, "_fill"}, 32'(fill_level), 32'd0);
      check({tag, "_total"}, total_bytes, 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset_n        = 1'b0;
      in_enable_byte = '0;
      in_val         = '0;
      in_flush       = 1'b0;
      out_ready      = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // Byte order across a 3+5 split
      out_ready = 1'b1;
      push(3, 64'hAABBCC, 1'b1);
      push(5, 64'h1122334455, 1'b1);
      wait_idle();
      check("order_total", total_bytes, 32'd8);

      // Flush with a 2-byte tail
      push(6, 64'h010203040506, 1'b1);
      flush(1'b0);
      wait_idle();
      check("partial_in_ready", 32'(in_ready), 32'd1);
      check("partial_total", total_bytes, 32'd14);

      // Exact multiple, second word still in FIFO at flush
      out_ready = 1'b0;
      push(8, 64'hA1A2A3A4A5A6A7A8, 1'b1);
      flush(1'b0);
      repeat (3) tick();
      out_ready = 1'b1;
      wait_idle();

      // Exact multiple, everything already emitted: marker word
      push(8, 64'hB1B2B3B4B5B6B7B8, 1'b1);
      wait_idle();
      flush(1'b1);
      wait_idle();
      check("marker_total", total_bytes, exp_total);

      // Backpressure
      out_ready = 1'b0;
      push(4, 64'hC0C1C2C3, 1'b1);
      push(4, 64'hC4C5C6C7, 1'b1);
      push(4, 64'hC8C9CACB, 1'b1);
      check("bp_fill", 32'(fill_level), 32'd8);
      repeat (7) tick();
      check("bp_fill_hold", 32'(fill_level), 32'd8);
      check("bp_data_hold", out_data, 32'hC0C1C2C3);
      out_ready = 1'b1;
      wait_idle();
      check("bp_total", total_bytes, exp_total);

      // Randomised stream with random backpressure
      for (int c = 0; c < 300; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (in_ready && ($urandom_range(0, 1) == 1))
            push(int'($urandom_range(0, 8)), {$urandom, $urandom}, 1'b1);
         else
            tick();
      end
      out_ready = 1'b1;
      wait_idle();
      flush(1'b1);
      wait_idle();
      check("rand_total", total_bytes, exp_total);
      check("rand_fill", 32'(fill_level), 32'd0);

      // Overflow
      out_ready = 1'b0;
      push(8, 64'hD0D1D2D3D4D5D6D7, 1'b1);
      push(8, 64'hD8D9DADBDCDDDEDF, 1'b1);
      check("ovf_fill_pre", 32'(fill_level), 32'd12);
      check("ovf_in_ready", 32'(in_ready), 32'd0);
      check("ovf_flag_pre", 32'(overflow), 32'd0);
      push(8, 64'hEEEEEEEEEEEEEEEE, 1'b0);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_fill", 32'(fill_level), 32'd12);
      tick();
      check("ovf_sticky", 32'(overflow), 32'd1);
      out_ready = 1'b1;
      wait_idle();
      check("ovf_sticky_drain", 32'(overflow), 32'd1);
      check("ovf_fill_drain", 32'(fill_level), 32'd0);
      check("ovf_total", total_bytes, exp_total);

      // Reset with the FIFO half full
      out_ready = 1'b0;
      push(8, 64'hF0F1F2F3F4F5F6F7, 1'b1);
      push(4, 64'hF8F9FAFB, 1'b1);
      check("mid_fill", 32'(fill_level), 32'd8);
      reset_n = 1'b0;
      tick();
      check_all_zero("mid_reset");
      exp_q.delete();
      byte_q.delete();
      exp_total = '0;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      repeat (6) tick();
      check("post_reset_valid", 32'(out_valid), 32'd0);
      check("post_reset_fill", 32'(fill_level), 32'd0);
      check("post_reset_total", total_bytes, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
